// File: rtl/writeback_unit.sv
// Regfile writeback arbiter: ALU results take the write port every cycle,
// load results queue in a small FIFO, and a per-register scoreboard tracks outstanding loads.
module writeback_unit #(
  parameter int BIT_DATA = 8,
  parameter int SZB      = 4,
  parameter int DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                alu_valid,
  input  logic [SZB-1:0]      alu_addr,
  input  logic [BIT_DATA-1:0] alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [SZB-1:0]      ld_addr,
  input  logic [BIT_DATA-1:0] ld_data,
  input  logic                iss_ld,
  input  logic [SZB-1:0]      iss_addr,
  input  logic [SZB-1:0]      chk_addr0,
  input  logic [SZB-1:0]      chk_addr1,
  output logic                busy0,
  output logic                busy1,
  output logic                rd_we,
  output logic [SZB-1:0]      addr_rd,
  output logic [BIT_DATA-1:0] rd
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NREG = 2 ** SZB;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  logic [SZB-1:0]      fifo_addr [DEPTH];
  logic [BIT_DATA-1:0] fifo_data [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  src_e                rd_src;
  logic [NREG-1:0]     sb;
  logic [NREG-1:0]     sb_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Readiness comes from registered count only, so a pop never frees a slot combinationally.
  assign ld_ready = !reset && (count < CW'(DEPTH));
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (count != '0);

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= ld_addr;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_we   <= 1'b0;
      addr_rd <= '0;
      rd      <= '0;
      rd_src  <= SRC_ALU;
    end else if (alu_valid) begin
      rd_we   <= 1'b1;
      addr_rd <= alu_addr;
      rd      <= alu_data;
      rd_src  <= SRC_ALU;
    end else if (pop) begin
      rd_we   <= 1'b1;
      addr_rd <= fifo_addr[rd_ptr];
      rd      <= fifo_data[rd_ptr];
      rd_src  <= SRC_LD;
    end else begin
      rd_we   <= 1'b0;
      rd_src  <= SRC_ALU;
    end
  end

  // Clear is applied before set so a same-edge reissue keeps the register busy.
  always_comb begin
    sb_next = sb;
    if (rd_we && (rd_src == SRC_LD)) sb_next[addr_rd] = 1'b0;
    if (iss_ld)                      sb_next[iss_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) sb <= '0;
    else       sb <= sb_next;
  end

  assign busy0 = sb[chk_addr0];
  assign busy1 = sb[chk_addr1];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based reference model.
module tb_writeback_unit;

  logic       clock;
  logic       reset;
  logic       alu_valid;
  logic [3:0] alu_addr;
  logic [7:0] alu_data;
  logic       ld_valid;
  logic       ld_ready;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic       iss_ld;
  logic [3:0] iss_addr;
  logic [3:0] chk_addr0;
  logic [3:0] chk_addr1;
  logic       busy0;
  logic       busy1;
  logic       rd_we;
  logic [3:0] addr_rd;
  logic [7:0] rd;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.BIT_DATA(8), .SZB(4), .DEPTH(2)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .iss_ld(iss_ld), .iss_addr(iss_addr),
    .chk_addr0(chk_addr0), .chk_addr1(chk_addr1),
    .busy0(busy0), .busy1(busy1),
    .rd_we(rd_we), .addr_rd(addr_rd), .rd(rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
    iss_ld    = 1'b0; iss_addr = '0;
    chk_addr0 = '0;   chk_addr1 = '0;
  endtask

  // Reference model: pending loads as a queue, write port as plain registers, scoreboard as bit array.
  typedef struct packed { logic [3:0] a; logic [7:0] d; } ent_t;
  ent_t m_q[$];
  logic       m_we, m_src_ld;
  logic [3:0] m_addr;
  logic [7:0] m_rd;
  bit         m_sb [16];

  task automatic model_reset();
    m_q.delete();
    m_we = 1'b0; m_src_ld = 1'b0; m_addr = '0; m_rd = '0;
    for (int i = 0; i < 16; i++) m_sb[i] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    set_idle();
    reset = 1'b1;
    #1 check("reset_ld_ready_low", 32'(ld_ready), 32'(1'b0));
    @(posedge clock);
    @(negedge clock);
    #1 check("reset_ld_ready_low2", 32'(ld_ready), 32'(1'b0));
    @(posedge clock); #1;
    check("reset_rd_we", 32'(rd_we), 32'(1'b0));
    check("reset_addr_rd", 32'(addr_rd), 32'(4'h0));
    check("reset_rd", 32'(rd), 32'(8'h00));
    @(negedge clock);
    reset = 1'b0;
    #1 check("post_reset_ld_ready", 32'(ld_ready), 32'(1'b1));
    model_reset();
  endtask

  typedef struct {
    logic       alu_v; logic [3:0] alu_a; logic [7:0] alu_d;
    logic       ld_v;  logic [3:0] ld_a;  logic [7:0] ld_d;
    logic       iss;   logic [3:0] iss_a;
    logic [3:0] c0;    logic [3:0] c1;
    logic       e_ready; logic e_busy0; logic e_busy1;
    logic       e_we;  logic [3:0] e_addr; logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [15];

  task automatic random_cycle();
    logic acc, pp;
    ent_t e;
    @(negedge clock);
    alu_valid = ($urandom_range(0, 9) < 4);
    alu_addr  = 4'($urandom_range(0, 15));
    alu_data  = 8'($urandom_range(0, 255));
    ld_valid  = ($urandom_range(0, 1) == 1);
    ld_addr   = 4'($urandom_range(0, 15));
    ld_data   = 8'($urandom_range(0, 255));
    iss_ld    = ($urandom_range(0, 4) == 0);
    iss_addr  = 4'($urandom_range(0, 15));
    chk_addr0 = 4'($urandom_range(0, 15));
    chk_addr1 = 4'($urandom_range(0, 15));
    #1;
    check("rnd_ld_ready", 32'(ld_ready), 32'(m_q.size() < 2));
    check("rnd_busy0", 32'(busy0), 32'(m_sb[chk_addr0]));
    check("rnd_busy1", 32'(busy1), 32'(m_sb[chk_addr1]));
    acc = ld_valid && (m_q.size() < 2);
    pp  = !alu_valid && (m_q.size() > 0);
    if (m_we && m_src_ld) m_sb[m_addr] = 1'b0;
    if (iss_ld)           m_sb[iss_addr] = 1'b1;
    if (alu_valid) begin
      m_we = 1'b1; m_src_ld = 1'b0; m_addr = alu_addr; m_rd = alu_data;
    end else if (pp) begin
      e = m_q.pop_front();
      m_we = 1'b1; m_src_ld = 1'b1; m_addr = e.a; m_rd = e.d;
    end else begin
      m_we = 1'b0; m_src_ld = 1'b0;
    end
    if (acc) m_q.push_back('{a: ld_addr, d: ld_data});
    @(posedge clock); #1;
    check("rnd_rd_we", 32'(rd_we), 32'(m_we));
    if (m_we) begin
      check("rnd_addr_rd", 32'(addr_rd), 32'(m_addr));
      check("rnd_rd", 32'(rd), 32'(m_rd));
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    apply_reset();

    // Row i: inputs held for edge i; ready/busy checked before the edge, write port after it.
    tbl[0]  = '{1,4'd3,8'h5A, 0,4'd0,8'h00, 0,4'd0, 4'd0,4'd0, 1,0,0, 1,4'd3,8'h5A};
    tbl[1]  = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd0,4'd0, 1,0,0, 0,4'd3,8'h5A};
    tbl[2]  = '{0,4'd0,8'h00, 1,4'd5,8'h11, 0,4'd0, 4'd0,4'd0, 1,0,0, 0,4'd3,8'h5A};
    tbl[3]  = '{1,4'd1,8'h22, 0,4'd0,8'h00, 0,4'd0, 4'd0,4'd0, 1,0,0, 1,4'd1,8'h22};
    tbl[4]  = '{1,4'd2,8'h33, 0,4'd0,8'h00, 0,4'd0, 4'd0,4'd0, 1,0,0, 1,4'd2,8'h33};
    tbl[5]  = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd0,4'd0, 1,0,0, 1,4'd5,8'h11};
    tbl[6]  = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd0,4'd0, 1,0,0, 0,4'd5,8'h11};
    tbl[7]  = '{0,4'd0,8'h00, 0,4'd0,8'h00, 1,4'd7, 4'd7,4'd0, 1,0,0, 0,4'd5,8'h11};
    tbl[8]  = '{0,4'd0,8'h00, 1,4'd7,8'h44, 0,4'd0, 4'd7,4'd7, 1,1,1, 0,4'd5,8'h11};
    tbl[9]  = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd7,4'd0, 1,1,0, 1,4'd7,8'h44};
    tbl[10] = '{0,4'd0,8'h00, 0,4'd0,8'h00, 1,4'd7, 4'd7,4'd0, 1,1,0, 0,4'd7,8'h44};
    tbl[11] = '{0,4'd0,8'h00, 1,4'd7,8'h55, 0,4'd0, 4'd7,4'd0, 1,1,0, 0,4'd7,8'h44};
    tbl[12] = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd7,4'd0, 1,1,0, 1,4'd7,8'h55};
    tbl[13] = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd7,4'd0, 1,1,0, 0,4'd7,8'h55};
    tbl[14] = '{0,4'd0,8'h00, 0,4'd0,8'h00, 0,4'd0, 4'd7,4'd0, 1,0,0, 0,4'd7,8'h55};

    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      alu_valid = tbl[i].alu_v; alu_addr = tbl[i].alu_a; alu_data = tbl[i].alu_d;
      ld_valid  = tbl[i].ld_v;  ld_addr  = tbl[i].ld_a;  ld_data  = tbl[i].ld_d;
      iss_ld    = tbl[i].iss;   iss_addr = tbl[i].iss_a;
      chk_addr0 = tbl[i].c0;    chk_addr1 = tbl[i].c1;
      #1;
      check($sformatf("vec%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].e_ready));
      check($sformatf("vec%0d_busy0", i), 32'(busy0), 32'(tbl[i].e_busy0));
      check($sformatf("vec%0d_busy1", i), 32'(busy1), 32'(tbl[i].e_busy1));
      @(posedge clock); #1;
      check($sformatf("vec%0d_rd_we", i), 32'(rd_we), 32'(tbl[i].e_we));
      check($sformatf("vec%0d_addr_rd", i), 32'(addr_rd), 32'(tbl[i].e_addr));
      check($sformatf("vec%0d_rd", i), 32'(rd), 32'(tbl[i].e_rd));
    end

    // Full FIFO under continuous ALU traffic, then drain in order.
    @(negedge clock);
    set_idle();
    alu_valid = 1; alu_addr = 4'd8; alu_data = 8'hB0;
    ld_valid = 1; ld_addr = 4'd1; ld_data = 8'hA1;
    #1 check("full_ready_c0", 32'(ld_ready), 32'(1'b1));
    @(negedge clock);
    alu_addr = 4'd9; alu_data = 8'hB1;
    ld_addr = 4'd2; ld_data = 8'hA2;
    #1 check("full_ready_c1", 32'(ld_ready), 32'(1'b1));
    @(negedge clock);
    ld_valid = 0; alu_addr = 4'd10; alu_data = 8'hB2;
    #1 check("full_ready_c2", 32'(ld_ready), 32'(1'b0));
    check("full_alu_we", 32'(rd_we), 32'(1'b1));
    check("full_alu_rd", 32'(rd), 32'(8'hB1));
    @(negedge clock);
    alu_valid = 0;
    #1 check("full_ready_c3", 32'(ld_ready), 32'(1'b0));
    @(posedge clock); #1;
    check("drain0_we", 32'(rd_we), 32'(1'b1));
    check("drain0_addr", 32'(addr_rd), 32'(4'd1));
    check("drain0_rd", 32'(rd), 32'(8'hA1));
    check("drain0_ready", 32'(ld_ready), 32'(1'b1));
    @(posedge clock); #1;
    check("drain1_we", 32'(rd_we), 32'(1'b1));
    check("drain1_addr", 32'(addr_rd), 32'(4'd2));
    check("drain1_rd", 32'(rd), 32'(8'hA2));
    @(posedge clock); #1;
    check("drain2_we", 32'(rd_we), 32'(1'b0));

    // Reset mid-flight with two buffered loads and an outstanding issue.
    @(negedge clock);
    alu_valid = 1; alu_addr = 4'd3; alu_data = 8'hC0;
    ld_valid = 1; ld_addr = 4'd9; ld_data = 8'hD1;
    iss_ld = 1; iss_addr = 4'd9;
    @(negedge clock);
    iss_ld = 0; ld_addr = 4'd9; ld_data = 8'hD2;
    @(negedge clock);
    ld_valid = 0; chk_addr0 = 4'd9;
    #1 check("mid_busy_before", 32'(busy0), 32'(1'b1));
    check("mid_ready_full", 32'(ld_ready), 32'(1'b0));
    reset = 1;
    alu_valid = 0;
    #1 check("mid_ready_in_reset", 32'(ld_ready), 32'(1'b0));
    @(posedge clock); #1;
    check("mid_rd_we", 32'(rd_we), 32'(1'b0));
    @(negedge clock);
    reset = 0;
    #1 check("mid_ready_after", 32'(ld_ready), 32'(1'b1));
    check("mid_busy_after", 32'(busy0), 32'(1'b0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      check($sformatf("mid_no_write%0d", i), 32'(rd_we), 32'(1'b0));
    end

    apply_reset();
    for (int n = 0; n < 3000; n++) random_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
